// File: rtl/stack_sequencer_if.sv
// Bundle between the stack sequencer and its surroundings: op handshake, register-file
// write port, data-memory port and the PC/flags load strobes.
interface stack_sequencer_if #(
   parameter int DW = 8
);
   logic          op_valid;
   logic          op_ready;
   logic [2:0]    op_code;
   logic [1:0]    op_reg;
   logic [DW-1:0] op_data;
   logic [DW-1:0] op_target;
   logic [3:0]    flags_in;
   logic [DW-1:0] sp_in;

   logic          rf_wr_en;
   logic [1:0]    rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          sp_inc;

   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   logic          pc_load;
   logic [DW-1:0] pc_value;
   logic          flags_load;
   logic [3:0]    flags_value;
   logic          done;
   logic          err;
   logic          stack_err;

   // master is the sequencer: it drives the register file, memory and PC/flags loads
   modport master (
      input  op_valid, op_code, op_reg, op_data, op_target, flags_in, sp_in,
             mem_rdata, mem_ack,
      output op_ready, rf_wr_en, rf_waddr, rf_wdata, sp_inc,
             mem_req, mem_we, mem_addr, mem_wdata,
             pc_load, pc_value, flags_load, flags_value, done, err, stack_err
   );

   modport slave (
      output op_valid, op_code, op_reg, op_data, op_target, flags_in, sp_in,
             mem_rdata, mem_ack,
      input  op_ready, rf_wr_en, rf_waddr, rf_wdata, sp_inc,
             mem_req, mem_we, mem_addr, mem_wdata,
             pc_load, pc_value, flags_load, flags_value, done, err, stack_err
   );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH/POP/CALL/RET/INT/RTI controller on a full-descending stack whose
// pointer lives in R3; all outputs are registered straight out of the state machine.
module stack_sequencer #(
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              rst,
   stack_sequencer_if.master bus
);
   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_POP  = 3'b001;
   localparam logic [2:0] OP_CALL = 3'b010;
   localparam logic [2:0] OP_RET  = 3'b011;
   localparam logic [2:0] OP_INT  = 3'b100;
   localparam logic [2:0] OP_RTI  = 3'b101;

   localparam logic [DW-1:0] SP_TOP = '1;
   localparam logic [DW-1:0] ONE    = DW'(1);

   typedef enum logic [2:0] {IDLE, MWR, SPDEC, SPINC, MRD, WB, DONE} state_t;

   state_t        state;
   logic          phase;
   logic [2:0]    op_q;
   logic [1:0]    reg_q;
   logic [DW-1:0] target_q;
   logic [3:0]    flags_q;
   logic [3:0]    pop_flags_q;

   function automatic logic stack_fault(input logic [2:0] code, input logic [DW-1:0] sp);
      case (code)
         OP_PUSH, OP_CALL: stack_fault = (sp == '0);
         OP_INT:           stack_fault = (sp <= ONE);
         OP_POP, OP_RET:   stack_fault = (sp == SP_TOP);
         OP_RTI:           stack_fault = (sp >= SP_TOP - ONE);
         default:          stack_fault = 1'b0;
      endcase
   endfunction

   function automatic logic is_push_op(input logic [2:0] code);
      is_push_op = (code == OP_PUSH) || (code == OP_CALL) || (code == OP_INT);
   endfunction

   // Addresses are computed one cycle ahead: SP writes land at the end of SPDEC/SPINC,
   // so the registered address must already reflect the value sp_in will show next.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         phase           <= 1'b0;
         op_q            <= '0;
         reg_q           <= '0;
         target_q        <= '0;
         flags_q         <= '0;
         pop_flags_q     <= '0;
         bus.op_ready    <= 1'b1;
         bus.rf_wr_en    <= 1'b0;
         bus.rf_waddr    <= '0;
         bus.rf_wdata    <= '0;
         bus.sp_inc      <= 1'b0;
         bus.mem_req     <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.pc_load     <= 1'b0;
         bus.pc_value    <= '0;
         bus.flags_load  <= 1'b0;
         bus.flags_value <= '0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
         bus.stack_err   <= 1'b0;
      end else begin
         bus.rf_wr_en   <= 1'b0;
         bus.sp_inc     <= 1'b0;
         bus.pc_load    <= 1'b0;
         bus.flags_load <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.op_valid && bus.op_ready) begin
                  op_q         <= bus.op_code;
                  reg_q        <= bus.op_reg;
                  target_q     <= bus.op_target;
                  flags_q      <= bus.flags_in;
                  phase        <= 1'b0;
                  bus.op_ready <= 1'b0;
                  if (bus.op_code[2:1] == 2'b11) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else if (stack_fault(bus.op_code, bus.sp_in)) begin
                     state         <= DONE;
                     bus.done      <= 1'b1;
                     bus.err       <= 1'b1;
                     bus.stack_err <= 1'b1;
                  end else if (is_push_op(bus.op_code)) begin
                     state         <= MWR;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= bus.sp_in;
                     bus.mem_wdata <= bus.op_data;
                  end else begin
                     state      <= SPINC;
                     bus.sp_inc <= 1'b1;
                  end
               end
            end

            MWR: begin
               if (bus.mem_ack) begin
                  state        <= SPDEC;
                  bus.mem_req  <= 1'b0;
                  bus.mem_we   <= 1'b0;
                  bus.rf_wr_en <= 1'b1;
                  bus.rf_waddr <= 2'd3;
                  bus.rf_wdata <= bus.sp_in - ONE;
               end
            end

            SPDEC: begin
               if (op_q == OP_INT && !phase) begin
                  phase         <= 1'b1;
                  state         <= MWR;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= bus.sp_in - ONE;
                  bus.mem_wdata <= {{(DW-4){1'b0}}, flags_q};
               end else begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  if (op_q == OP_CALL || op_q == OP_INT) begin
                     bus.pc_load  <= 1'b1;
                     bus.pc_value <= target_q;
                  end
               end
            end

            SPINC: begin
               state        <= MRD;
               bus.mem_req  <= 1'b1;
               bus.mem_we   <= 1'b0;
               bus.mem_addr <= bus.sp_in + ONE;
            end

            MRD: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  pop_flags_q <= bus.mem_rdata[3:0];
                  if (op_q == OP_POP) begin
                     state        <= WB;
                     bus.rf_wr_en <= 1'b1;
                     bus.rf_waddr <= reg_q;
                     bus.rf_wdata <= bus.mem_rdata;
                  end else if (op_q == OP_RTI && !phase) begin
                     phase      <= 1'b1;
                     state      <= SPINC;
                     bus.sp_inc <= 1'b1;
                  end else begin
                     state        <= DONE;
                     bus.done     <= 1'b1;
                     bus.pc_load  <= 1'b1;
                     bus.pc_value <= bus.mem_rdata;
                     if (op_q == OP_RTI) begin
                        bus.flags_load  <= 1'b1;
                        bus.flags_value <= pop_flags_q;
                     end
                  end
               end
            end

            WB: begin
               state    <= DONE;
               bus.done <= 1'b1;
            end

            DONE: begin
               state        <= IDLE;
               bus.op_ready <= 1'b1;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: models the register file and a wait-state memory around the
// DUT and compares every operation against a plain stack model.
module tb_stack_sequencer;
   logic       clk;
   logic       rst;
   logic       poke_en;
   logic [7:0] poke_val;
   int         wait_cfg;
   int         wcnt;
   int         checks;
   int         failures;

   logic [7:0] rf [4];
   logic [7:0] mem [256];
   logic [7:0] pc_reg;
   logic [3:0] flg_reg;
   int         pc_loads;
   int         fl_loads;
   int         xfers;

   logic [7:0] ref_rf [4];
   logic [7:0] ref_mem [256];
   logic [7:0] ref_pc;
   logic [3:0] ref_flags;
   logic       ref_stack_err;

   stack_sequencer_if #(.DW(8)) bus ();

   stack_sequencer #(.DW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      return 8'(i * 37 + 11);
   endfunction

   assign bus.sp_in     = rf[3];
   assign bus.mem_ack   = bus.mem_req && (wcnt == wait_cfg);
   assign bus.mem_rdata = mem[bus.mem_addr];

   // surrounding register file, memory and PC/flags registers
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf[0] <= 8'h00;
         rf[1] <= 8'h00;
         rf[2] <= 8'h00;
         rf[3] <= 8'hFF;
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         wcnt     <= 0;
         pc_reg   <= 8'h00;
         flg_reg  <= 4'h0;
         pc_loads <= 0;
         fl_loads <= 0;
         xfers    <= 0;
      end else begin
         if (poke_en) rf[3] <= poke_val;
         if (bus.rf_wr_en) rf[bus.rf_waddr] <= bus.rf_wdata;
         else if (bus.sp_inc) rf[3] <= rf[3] + 8'd1;
         if (bus.mem_req) begin
            if (bus.mem_ack) begin
               wcnt  <= 0;
               xfers <= xfers + 1;
               if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            end else begin
               wcnt <= wcnt + 1;
            end
         end
         if (bus.pc_load) begin
            pc_reg   <= bus.pc_value;
            pc_loads <= pc_loads + 1;
         end
         if (bus.flags_load) begin
            flg_reg  <= bus.flags_value;
            fl_loads <= fl_loads + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ref_rf[0] = 8'h00;
      ref_rf[1] = 8'h00;
      ref_rf[2] = 8'h00;
      ref_rf[3] = 8'hFF;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_pc        = 8'h00;
      ref_flags     = 4'h0;
      ref_stack_err = 1'b0;
   endtask

   // Stack semantics straight from the op definitions, plus the documented busy-cycle counts
   task automatic model_op(input logic [2:0] code, input logic [1:0] r, input logic [7:0] d,
                           input logic [7:0] t, input logic [3:0] f, input int w,
                           output bit e, output int cyc, output int nx, output int npc,
                           output int nfl);
      logic [7:0] sp;
      logic [7:0] v1;
      logic [7:0] v2;
      int base;
      sp = ref_rf[3];
      e = 0; nx = 0; npc = 0; nfl = 0; base = 1;
      case (code)
         3'd0, 3'd2: begin
            base = 3;
            if (sp == 8'd0) e = 1;
            else begin
               ref_mem[sp] = d;
               ref_rf[3] = sp - 8'd1;
               nx = 1;
               if (code == 3'd2) begin ref_pc = t; npc = 1; end
            end
         end
         3'd4: begin
            base = 5;
            if (sp <= 8'd1) e = 1;
            else begin
               ref_mem[sp] = d;
               ref_mem[sp - 8'd1] = {4'h0, f};
               ref_rf[3] = sp - 8'd2;
               ref_pc = t; npc = 1; nx = 2;
            end
         end
         3'd1, 3'd3: begin
            base = (code == 3'd1) ? 4 : 3;
            if (sp == 8'hFF) e = 1;
            else begin
               sp = sp + 8'd1;
               v1 = ref_mem[sp];
               ref_rf[3] = sp;
               nx = 1;
               if (code == 3'd1) ref_rf[r] = v1;
               else begin ref_pc = v1; npc = 1; end
            end
         end
         3'd5: begin
            base = 5;
            if (sp >= 8'd254) e = 1;
            else begin
               v1 = ref_mem[sp + 8'd1];
               v2 = ref_mem[sp + 8'd2];
               ref_rf[3] = sp + 8'd2;
               ref_flags = v1[3:0];
               ref_pc = v2;
               npc = 1; nfl = 1; nx = 2;
            end
         end
         default: ;
      endcase
      if (e) ref_stack_err = 1'b1;
      cyc = (e || nx == 0) ? 1 : base + nx * w;
   endtask

   task automatic poke_sp(input logic [7:0] v);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_val = v;
      @(negedge clk);
      poke_en  = 1'b0;
      ref_rf[3] = v;
   endtask

   task automatic run_op(input logic [2:0] code, input logic [1:0] r, input logic [7:0] d,
                         input logic [7:0] t, input logic [3:0] f, input int w,
                         output int cyc);
      bit e;
      int ecyc, enx, epc, efl, pc0, fl0, x0, diffs;
      model_op(code, r, d, t, f, w, e, ecyc, enx, epc, efl);
      pc0 = pc_loads; fl0 = fl_loads; x0 = xfers;
      wait_cfg = w;
      @(negedge clk);
      bus.op_valid  = 1'b1;
      bus.op_code   = code;
      bus.op_reg    = r;
      bus.op_data   = d;
      bus.op_target = t;
      bus.flags_in  = f;
      check("ready_idle", bus.op_ready, 1);
      @(negedge clk);
      bus.op_valid = 1'b0;
      cyc = 1;
      check("busy_not_ready", bus.op_ready, 0);
      while (bus.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", bus.done, 1);
      check("cycles", cyc, ecyc);
      check("err_pulse", bus.err, e);
      @(negedge clk);
      check("ready_after", bus.op_ready, 1);
      check("done_one_cycle", bus.done, 0);
      for (int i = 0; i < 4; i++) check("rf", rf[i], ref_rf[i]);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check("mem_image", diffs, 0);
      check("pc", pc_reg, ref_pc);
      check("flags", flg_reg, ref_flags);
      check("pc_loads", pc_loads - pc0, epc);
      check("flag_loads", fl_loads - fl0, efl);
      check("mem_xfers", xfers - x0, enx);
      check("stack_err", bus.stack_err, ref_stack_err);
   endtask

   initial begin
      int cyc;
      logic [7:0] v;
      checks = 0; failures = 0;
      poke_en = 1'b0; poke_val = 8'h00; wait_cfg = 0;
      bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_reg = 2'd0;
      bus.op_data = 8'h00; bus.op_target = 8'h00; bus.flags_in = 4'h0;
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_ready", bus.op_ready, 1);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_rf_wr", bus.rf_wr_en, 0);
      check("rst_done", bus.done, 0);
      check("rst_stack_err", bus.stack_err, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_pc_value", bus.pc_value, 0);
      rst = 1'b1;

      run_op(3'd0, 2'd0, 8'h5A, 8'h00, 4'h0, 0, cyc);
      check("push_cycles", cyc, 3);
      check("push_mem", mem[8'hFF], 8'h5A);
      check("push_sp", rf[3], 8'hFE);

      run_op(3'd1, 2'd1, 8'h00, 8'h00, 4'h0, 0, cyc);
      check("pop_cycles", cyc, 4);
      check("pop_r1", rf[1], 8'h5A);
      check("pop_sp", rf[3], 8'hFF);

      run_op(3'd2, 2'd0, 8'h10, 8'h40, 4'h0, 2, cyc);
      check("call_mem", mem[8'hFF], 8'h10);
      check("call_pc", pc_reg, 8'h40);
      check("call_cycles", cyc, 5);
      run_op(3'd3, 2'd0, 8'h00, 8'h00, 4'h0, 2, cyc);
      check("ret_pc", pc_reg, 8'h10);
      check("ret_sp", rf[3], 8'hFF);

      run_op(3'd4, 2'd0, 8'h22, 8'h80, 4'hA, 0, cyc);
      check("int_mem_ff", mem[8'hFF], 8'h22);
      check("int_mem_fe", mem[8'hFE], 8'h0A);
      check("int_sp", rf[3], 8'hFD);
      check("int_pc", pc_reg, 8'h80);
      check("int_cycles", cyc, 5);
      run_op(3'd5, 2'd0, 8'h00, 8'h00, 4'h0, 0, cyc);
      check("rti_flags", flg_reg, 4'hA);
      check("rti_pc", pc_reg, 8'h22);
      check("rti_sp", rf[3], 8'hFF);

      run_op(3'd1, 2'd2, 8'h00, 8'h00, 4'h0, 0, cyc);
      check("underflow_cycles", cyc, 1);
      check("underflow_sticky", bus.stack_err, 1);
      poke_sp(8'h01);
      run_op(3'd4, 2'd0, 8'h66, 8'h90, 4'h5, 0, cyc);
      check("overflow_cycles", cyc, 1);
      check("overflow_sp", rf[3], 8'h01);
      poke_sp(8'h80);
      run_op(3'd0, 2'd0, 8'h77, 8'h00, 4'h0, 1, cyc);
      check("sticky_after_ok", bus.stack_err, 1);
      run_op(3'd7, 2'd0, 8'h00, 8'h00, 4'h0, 0, cyc);
      check("noop_cycles", cyc, 1);

      // abort an RTI while it waits in its first memory read
      poke_sp(8'h80);
      wait_cfg = 3;
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'd5;
      @(negedge clk);
      bus.op_valid = 1'b0;
      @(negedge clk);
      check("rti_mrd_req", bus.mem_req, 1);
      rst = 1'b0;
      #1;
      check("abort_mem_req", bus.mem_req, 0);
      check("abort_mem_addr", bus.mem_addr, 0);
      check("abort_sp_inc", bus.sp_inc, 0);
      check("abort_done", bus.done, 0);
      check("abort_stack_err", bus.stack_err, 0);
      check("abort_sp", rf[3], 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      check("abort_ready", bus.op_ready, 1);
      run_op(3'd0, 2'd0, 8'h33, 8'h00, 4'h0, 0, cyc);
      check("post_abort_push", mem[8'hFF], 8'h33);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
               0: v = 8'd0;
               1: v = 8'd1;
               2: v = 8'd2;
               3: v = 8'd253;
               4: v = 8'd254;
               default: v = 8'($urandom_range(0, 255));
            endcase
            poke_sp(v);
         end
         run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom),
                8'($urandom), 4'($urandom), $urandom_range(0, 2), cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller that runs stack operations (PUSH, POP, CALL, RET, INT, RTI) against the 4-entry register file, where R3 is the stack pointer (reset 255), and against the single data-memory port. It sits beside the decode/execute stage. While busy it owns the register-file write port and the SP_INC strobe. The stack is full-descending: a push writes mem[SP] and then SP←SP−1; a pop does SP←SP+1 and then reads mem[SP].

## Interface
- DW, 8, data/address width; SP is DW bits and wraps modulo 2^DW.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operation request.
- op_ready  out  1  high only in IDLE; an op is accepted on op_valid & op_ready.
- op_code  in  3  000 PUSH, 001 POP, 010 CALL, 011 RET, 100 INT, 101 RTI, 11x no-op.
- op_reg  in  2  destination register for POP.
- op_data  in  DW  push value (PUSH) or return PC (CALL/INT).
- op_target  in  DW  jump target (CALL) or vector (INT).
- flags_in  in  4  flags pushed by INT.
- sp_in  in  DW  live R3 value from the register file.
- rf_wr_en, rf_waddr[2], rf_wdata[DW]  out  register-file write port.
- sp_inc  out  1  one-cycle SP increment strobe.
- mem_req, mem_we  out  1 each  memory request and write flag.
- mem_addr, mem_wdata  out  DW each  memory address and write data.
- mem_rdata  in  DW  read data, valid with mem_ack.
- mem_ack  in  1  completes the current request.
- pc_load  out  1  one-cycle PC load strobe.
- pc_value  out  DW  PC value for pc_load.
- flags_load  out  1  one-cycle flags load strobe.
- flags_value  out  4  flags value for flags_load.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- stack_err  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, MWR, SPDEC, SPINC, MRD, WB, DONE. A phase bit selects the first or second transfer for INT and RTI.
- On accept, latch op_code, op_reg, op_data, op_target and flags_in. sp_in is always sampled live.
- Error check at accept, based on sp_in:
  - Overflow: PUSH/CALL with SP==0, or INT with SP≤1.
  - Underflow: POP/RET with SP==255, or RTI with SP≥254.
  - On error, go straight to DONE with err=1 and set stack_err. No memory, register or PC activity occurs.
- No-op codes (11x) go straight to DONE with no err.
- MWR: mem_req=1, mem_we=1, mem_addr=sp_in.
  - mem_wdata is op_data for the first push. For the second INT push it is {4'b0, flags}.
  - Hold until mem_ack, then go to SPDEC.
- SPDEC: rf_wr_en=1, rf_waddr=3, rf_wdata=sp_in−1 for one cycle.
  - Next state: MWR (INT phase 0) or DONE.
- SPINC: sp_inc=1 for one cycle, then MRD.
- MRD: mem_req=1, mem_we=0, mem_addr=sp_in. sp_in already holds the incremented SP here.
  - On mem_ack, capture mem_rdata.
  - Next state: WB (POP), SPINC (RTI phase 0), or DONE.
- WB: rf_wr_en=1, rf_waddr=op_reg, rf_wdata=captured data for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
  - CALL/INT: pc_load=1, pc_value=op_target.
  - RET: pc_load=1, pc_value=captured data.
  - RTI: flags_load=1 with flags_value = low 4 bits of the first pop, and pc_load=1 with pc_value = the second pop.
- Sequences:
  - PUSH: MWR, SPDEC, DONE.
  - CALL: MWR, SPDEC, DONE.
  - INT: MWR, SPDEC, MWR, SPDEC, DONE.
  - POP: SPINC, MRD, WB, DONE.
  - RET: SPINC, MRD, DONE.
  - RTI: SPINC, MRD, SPINC, MRD, DONE.
- Outside their state, rf_wr_en, sp_inc, mem_req, pc_load, flags_load, done and err are 0.
- op_reg==3 on POP writes R3 in WB; this intentionally overrides SP.

## Timing
- Reset (asynchronous): state IDLE, op_ready=1, all strobes 0, all data outputs 0, stack_err=0.
- Reset mid-operation aborts immediately. The register file shares rst, so SP returns to 255 consistently.
- Register writes issued in SPDEC, SPINC and WB take effect at the end of that cycle. The next state sees the new sp_in.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_ack in the same cycle as mem_req is legal (zero-wait).
  - mem_ack with mem_req=0 is ignored.
- Busy cycles after the accept edge, zero-wait memory: PUSH/CALL/RET 3, POP 4, INT/RTI 5, error/no-op 1. Each wait state adds 1 cycle per transfer.
- op_ready returns high in the cycle after done. Back-to-back ops therefore have a minimum 1-cycle gap.

## Test plan
- Reset, then PUSH op_data=0x5A, zero-wait memory -> mem write addr 0xFF data 0x5A; R3 write 0xFE; done in cycle 3.
- Then POP op_reg=1 -> sp_inc; mem read at 0xFF returning 0x5A; R1 write 0x5A; done in cycle 4; SP=0xFF.
- CALL op_data=0x10, op_target=0x40, then RET with 2 wait states on each access -> 0x10 stored at 0xFF; done with pc_load 0x40; RET pc_load 0x10; SP back to 0xFF.
- INT flags_in=0xA, op_data=0x22, op_target=0x80, then RTI -> mem[0xFF]=0x22, mem[0xFE]=0x0A, SP=0xFD, pc_load 0x80; RTI gives flags_load 0xA, pc_load 0x22, SP=0xFF.
- POP with SP=0xFF, and INT with SP=0x01 -> no memory or register activity; done+err after 1 cycle; stack_err stays 1 until reset.
- Assert rst in MRD of an RTI -> all outputs 0 immediately; op_ready=1 after release; the next PUSH writes to 0xFF.
